// File: rtl/alu_pkg.sv
// Shared ALU issue definitions: ALUOp encodings and the 4-bit ALU operation codes.
package alu_pkg;

  typedef enum logic [1:0] {
    ALUOP_ADD = 2'b00,  // loads/stores: address add
    ALUOP_BR  = 2'b01,  // branch compare
    ALUOP_R   = 2'b10,  // register-register ALU
    ALUOP_I   = 2'b11   // register-immediate ALU
  } aluop_t;

  localparam int OP_W = 4;

  localparam logic [OP_W-1:0] OP_AND = 4'b0000;
  localparam logic [OP_W-1:0] OP_OR  = 4'b0001;
  localparam logic [OP_W-1:0] OP_ADD = 4'b0010;
  localparam logic [OP_W-1:0] OP_SUB = 4'b0011;
  localparam logic [OP_W-1:0] OP_SLL = 4'b0100;
  localparam logic [OP_W-1:0] OP_SRL = 4'b0101;
  localparam logic [OP_W-1:0] OP_SRA = 4'b0111;
  localparam logic [OP_W-1:0] OP_BEQ = 4'b1000;
  localparam logic [OP_W-1:0] OP_XOR = 4'b1001;
  localparam logic [OP_W-1:0] OP_BNE = 4'b1010;
  localparam logic [OP_W-1:0] OP_SLT = 4'b1100;
  localparam logic [OP_W-1:0] OP_BGE = 4'b1101;
  localparam logic [OP_W-1:0] OP_BLT = 4'b1110;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

endpackage

// File: rtl/alu_op_decode.sv
// Combinational ALUOp/funct3/funct7 -> ALU operation code decode.
// Unsupported encodings produce OP_AND (0000) with illegal raised.
module alu_op_decode
  import alu_pkg::*;
(
  input  logic [1:0]      alu_op,
  input  logic [2:0]      funct3,
  input  logic [6:0]      funct7,
  output logic [OP_W-1:0] op,
  output logic            illegal
);

  aluop_t aop;
  logic   is_i;

  assign aop  = aluop_t'(alu_op);
  assign is_i = (aop == ALUOP_I);

  // Decode the instruction class and function fields into one ALU code.
  always_comb begin
    op      = OP_AND;
    illegal = 1'b0;
    case (aop)
      ALUOP_ADD: op = OP_ADD;
      ALUOP_BR: begin
        case (funct3)
          3'b000:  op = OP_BEQ;
          3'b001:  op = OP_BNE;
          3'b100:  op = OP_BLT;
          3'b101:  op = OP_BGE;
          default: illegal = 1'b1;
        endcase
      end
      default: begin
        case (funct3)
          // Immediate adds have no subtract form, so funct7 only matters for R-type.
          3'b000: op = (!is_i && funct7[5]) ? OP_SUB : OP_ADD;
          3'b001: begin
            if (is_i && funct7 != F7_BASE) illegal = 1'b1;
            else                           op = OP_SLL;
          end
          3'b010: op = OP_SLT;
          3'b011: illegal = 1'b1;  // sltu has no ALU code
          3'b100: op = OP_XOR;
          3'b101: begin
            if (is_i && funct7 != F7_BASE && funct7 != F7_ALT) illegal = 1'b1;
            else op = funct7[5] ? OP_SRA : OP_SRL;
          end
          3'b110: op = OP_OR;
          default: op = OP_AND;
        endcase
      end
    endcase
  end

endmodule

// File: rtl/alu_issue_stage.sv
// ID->EX issue stage: decodes the ALU operation, selects operands and holds
// them in a one-entry valid/ready register feeding the ALU directly.
// Optional macro ALU_ISSUE_FWD_EN enables EX/MEM -> operand forwarding.
module alu_issue_stage
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int OPCODE_LENGTH = 4,
  parameter int REG_ADDR_W    = 5
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [1:0]               alu_op,
  input  logic [2:0]               funct3,
  input  logic [6:0]               funct7,
  input  logic                     alu_src,
  input  logic [REG_ADDR_W-1:0]    rs1_addr,
  input  logic [REG_ADDR_W-1:0]    rs2_addr,
  input  logic [DATA_WIDTH-1:0]    rs1_data,
  input  logic [DATA_WIDTH-1:0]    rs2_data,
  input  logic [DATA_WIDTH-1:0]    imm,
  input  logic [REG_ADDR_W-1:0]    rd_in,
  input  logic                     flush,
  input  logic                     fwd_valid,
  input  logic [REG_ADDR_W-1:0]    fwd_rd,
  input  logic [DATA_WIDTH-1:0]    fwd_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_WIDTH-1:0]    SrcA,
  output logic [DATA_WIDTH-1:0]    SrcB,
  output logic [OPCODE_LENGTH-1:0] Operation,
  output logic [REG_ADDR_W-1:0]    rd_out,
  output logic                     illegal
);

  logic [OP_W-1:0]          dec_op;
  logic                     dec_ill;
  logic [DATA_WIDTH-1:0]    src_a, src_b;
  logic                     load;

  logic                     out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0]    src_a_q, src_a_d;
  logic [DATA_WIDTH-1:0]    src_b_q, src_b_d;
  logic [OPCODE_LENGTH-1:0] op_q, op_d;
  logic [REG_ADDR_W-1:0]    rd_q, rd_d;
  logic                     ill_q, ill_d;

  alu_op_decode u_dec (
    .alu_op  (alu_op),
    .funct3  (funct3),
    .funct7  (funct7),
    .op      (dec_op),
    .illegal (dec_ill)
  );

`ifdef ALU_ISSUE_FWD_EN
  logic [DATA_WIDTH-1:0] rs2_fwd;

  // Substitute the in-flight EX/MEM result for a matching source; x0 never forwards.
  always_comb begin
    src_a   = rs1_data;
    rs2_fwd = rs2_data;
    if (fwd_valid && fwd_rd != '0 && fwd_rd == rs1_addr) src_a   = fwd_data;
    if (fwd_valid && fwd_rd != '0 && fwd_rd == rs2_addr) rs2_fwd = fwd_data;
    src_b = alu_src ? imm : rs2_fwd;
  end
`else
  logic unused_fwd;
  assign unused_fwd = ^{fwd_valid, fwd_rd, fwd_data, rs1_addr, rs2_addr};

  // Operands come straight from the register file read ports or the immediate.
  always_comb begin
    src_a = rs1_data;
    src_b = alu_src ? imm : rs2_data;
  end
`endif

  assign in_ready = !out_valid_q || out_ready;
  assign load     = in_valid && in_ready && !flush;

  // Next-state for the holding register: flush kills, load replaces, consume drains.
  always_comb begin
    out_valid_d = out_valid_q;
    src_a_d     = src_a_q;
    src_b_d     = src_b_q;
    op_d        = op_q;
    rd_d        = rd_q;
    ill_d       = ill_q;
    if (flush) begin
      out_valid_d = 1'b0;
    end else if (load) begin
      out_valid_d = 1'b1;
      src_a_d     = src_a;
      src_b_d     = src_b;
      op_d        = OPCODE_LENGTH'(dec_op);
      rd_d        = rd_in;
      ill_d       = dec_ill;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // Stage register with synchronous reset clearing payload as well as valid.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      src_a_q     <= '0;
      src_b_q     <= '0;
      op_q        <= '0;
      rd_q        <= '0;
      ill_q       <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      src_a_q     <= src_a_d;
      src_b_q     <= src_b_d;
      op_q        <= op_d;
      rd_q        <= rd_d;
      ill_q       <= ill_d;
    end
  end

  assign out_valid = out_valid_q;
  assign SrcA      = src_a_q;
  assign SrcB      = src_b_q;
  assign Operation = op_q;
  assign rd_out    = rd_q;
  assign illegal   = ill_q;

endmodule
